// File: rtl/amp_mod_pkg.sv
// Shared definitions for the multi-channel amplitude modulator: state encoding,
// default sizing and the channel packing helper.
package amp_mod_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_CHANNELS  = 2;
    localparam int DEF_GAIN_STEP = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_ENV  = 2'd1,
        MUL_GAIN = 2'd2,
        DONE     = 2'd3
    } state_e;

    // LSB position of channel ch inside a packed CHANNELS*width vector.
    function automatic int ch_lsb(input int ch, input int width);
        return ch * width;
    endfunction

endpackage

// File: rtl/amplitude_modulator_mc_serial_mul.sv
// Unsigned LSB-first shift-add multiplier. The start cycle performs the first
// partial-product step, so a full product appears after exactly WIDTH cycles.
module serial_mul #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int CNT_W = $clog2(WIDTH);

    logic [2*WIDTH-1:0] acc_q, mcand_q;
    logic [2*WIDTH-1:0] acc_cur, mcand_cur, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_cur;
    logic [CNT_W-1:0]   cnt_q, cnt_cur;
    logic               run_q;
    logic               active;

    always_comb begin
        acc_cur    = start ? '0 : acc_q;
        mcand_cur  = start ? {{WIDTH{1'b0}}, a} : mcand_q;
        mplier_cur = start ? b : mplier_q;
        cnt_cur    = start ? '0 : cnt_q;
        acc_d      = acc_cur + (mplier_cur[0] ? mcand_cur : '0);
        active     = start | run_q;
        done       = active && (cnt_cur == CNT_W'(WIDTH - 1));
    end

    // Product is the post-step accumulator so it is usable in the done cycle.
    assign product = acc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else if (active) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_cur << 1;
            mplier_q <= mplier_cur >> 1;
            cnt_q    <= cnt_cur + 1'b1;
            run_q    <= !done;
        end
    end

endmodule

// File: rtl/amplitude_modulator_mc.sv
// Multi-channel amplitude modulator: wave x envelope x ramped master gain,
// all channels time-shared through one serial multiplier.
module amplitude_modulator_mc
    import amp_mod_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int CHANNELS  = DEF_CHANNELS,
    parameter int GAIN_STEP = DEF_GAIN_STEP
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sample_valid,
    input  logic [CHANNELS*WIDTH-1:0]    waveform_in,
    input  logic [CHANNELS*WIDTH-1:0]    envelope_in,
    input  logic [WIDTH-1:0]             master_gain,
    input  logic                         mute,
    input  logic                         overrun_clr,
    output logic [CHANNELS*WIDTH-1:0]    amp_out,
    output logic                         out_valid,
    output logic                         busy,
    output logic                         overrun,
    output logic [WIDTH-1:0]             gain_current
);
    localparam int VW   = CHANNELS * WIDTH;
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [WIDTH-1:0] STEP_V = WIDTH'(GAIN_STEP);

    state_e             state_q, state_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic               start_q, start_d;
    logic [VW-1:0]      wave_q, env_q;
    logic [WIDTH-1:0]   gain_q, stage1_q, gain_cur_q;
    logic               overrun_q;
    logic [WIDTH-1:0]   hold_q [CHANNELS];
    logic [WIDTH-1:0]   amp_q  [CHANNELS];

    logic [WIDTH-1:0]   mul_a, mul_b, prod_hi, gain_res, target, gain_ramp;
    logic [2*WIDTH-1:0] mul_prod;
    logic               mul_done, is_last, gain_step_done;

    assign mul_a   = (state_q == MUL_ENV) ? wave_q[ch_lsb(int'(ch_q), WIDTH) +: WIDTH] : stage1_q;
    assign mul_b   = (state_q == MUL_ENV) ? env_q[ch_lsb(int'(ch_q), WIDTH) +: WIDTH] : gain_q;
    assign prod_hi = mul_prod[2*WIDTH-1:WIDTH];
    // Full-scale gain is treated as exact unity rather than 255/256.
    assign gain_res = (gain_q == '1) ? stage1_q : prod_hi;
    assign is_last  = (ch_q == CH_W'(CHANNELS - 1));
    assign gain_step_done = (state_q == MUL_GAIN) && mul_done;

    serial_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start_q),
        .a       (mul_a),
        .b       (mul_b),
        .done    (mul_done),
        .product (mul_prod)
    );

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        start_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (sample_valid) begin
                    state_d = MUL_ENV;
                    ch_d    = '0;
                    start_d = 1'b1;
                end
            end
            MUL_ENV: begin
                if (mul_done) begin
                    state_d = MUL_GAIN;
                    start_d = 1'b1;
                end
            end
            MUL_GAIN: begin
                if (mul_done) begin
                    if (is_last) begin
                        state_d = DONE;
                    end else begin
                        state_d = MUL_ENV;
                        ch_d    = CH_W'(ch_q + 1'b1);
                        start_d = 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Slew toward the target, landing exactly on it instead of overshooting.
    always_comb begin
        target    = mute ? '0 : master_gain;
        gain_ramp = gain_cur_q;
        if (gain_cur_q < target) begin
            gain_ramp = ((target - gain_cur_q) > STEP_V) ? gain_cur_q + STEP_V : target;
        end else if (gain_cur_q > target) begin
            gain_ramp = ((gain_cur_q - target) > STEP_V) ? gain_cur_q - STEP_V : target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ch_q       <= '0;
            start_q    <= 1'b0;
            wave_q     <= '0;
            env_q      <= '0;
            gain_q     <= '0;
            stage1_q   <= '0;
            gain_cur_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            start_q <= start_d;
            if (state_q == IDLE && sample_valid) begin
                wave_q <= waveform_in;
                env_q  <= envelope_in;
                gain_q <= gain_cur_q;
            end
            if (state_q == MUL_ENV && mul_done) begin
                stage1_q <= prod_hi;
            end
            if (state_q == DONE) begin
                gain_cur_q <= gain_ramp;
            end
            if (sample_valid && state_q != IDLE) begin
                overrun_q <= 1'b1;
            end else if (overrun_clr) begin
                overrun_q <= 1'b0;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hold_q[gi] <= '0;
                    amp_q[gi]  <= '0;
                end else if (gain_step_done) begin
                    if (ch_q == CH_W'(gi)) begin
                        hold_q[gi] <= gain_res;
                    end
                    // The last channel bypasses its holding register into amp_q.
                    if (is_last) begin
                        amp_q[gi] <= (ch_q == CH_W'(gi)) ? gain_res : hold_q[gi];
                    end
                end
            end
            assign amp_out[gi*WIDTH +: WIDTH] = amp_q[gi];
        end
    endgenerate

    assign out_valid    = (state_q == DONE);
    assign busy         = (state_q != IDLE);
    assign overrun      = overrun_q;
    assign gain_current = gain_cur_q;

endmodule

// File: tb/tb_amplitude_modulator_mc.sv
// Randomised and directed bench for amplitude_modulator_mc with a frame-level
// arithmetic reference model checked every cycle.
module tb_amplitude_modulator_mc;
    localparam int W    = 8;
    localparam int CH   = 2;
    localparam int STEP = 16;
    localparam int CW   = CH * W;
    localparam int L    = CH * 2 * W;
    localparam int LAST = L + 1;
    localparam int MAXV = (1 << W) - 1;

    logic          clk, rst_n, sample_valid, mute, overrun_clr;
    logic [CW-1:0] waveform_in, envelope_in, amp_out;
    logic [W-1:0]  master_gain, gain_current;
    logic          out_valid, busy, overrun;

    int n_vec = 0;
    int n_err = 0;

    amplitude_modulator_mc #(.WIDTH(W), .CHANNELS(CH), .GAIN_STEP(STEP)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .waveform_in  (waveform_in),
        .envelope_in  (envelope_in),
        .master_gain  (master_gain),
        .mute         (mute),
        .overrun_clr  (overrun_clr),
        .amp_out      (amp_out),
        .out_valid    (out_valid),
        .busy         (busy),
        .overrun      (overrun),
        .gain_current (gain_current)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference arithmetic: two truncating fractional multiplies, unity at full-scale gain.
    function automatic logic [CW-1:0] frame_result(input logic [CW-1:0] w, input logic [CW-1:0] e,
                                                   input logic [W-1:0] g);
        logic [CW-1:0] r;
        r = '0;
        for (int c = 0; c < CH; c++) begin
            int unsigned s1, res;
            s1  = (int'(w[c*W +: W]) * int'(e[c*W +: W])) / (1 << W);
            res = (int'(g) == MAXV) ? s1 : (s1 * int'(g)) / (1 << W);
            r[c*W +: W] = W'(res);
        end
        return r;
    endfunction

    function automatic logic [W-1:0] ramp(input logic [W-1:0] cur, input logic [W-1:0] tgt);
        int c, t;
        c = int'(cur);
        t = int'(tgt);
        if (c < t) return W'((t - c > STEP) ? c + STEP : t);
        if (c > t) return W'((c - t > STEP) ? c - STEP : t);
        return cur;
    endfunction

    // Model: m_p counts edges since acceptance (0 = idle, LAST = output cycle).
    int            m_p;
    logic [W-1:0]  m_gain;
    logic [CW-1:0] m_pending, m_amp;
    logic          m_ovr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_p       <= 0;
            m_gain    <= '0;
            m_pending <= '0;
            m_amp     <= '0;
            m_ovr     <= 1'b0;
        end else begin
            if (m_p == 0) begin
                if (sample_valid) begin
                    m_p       <= 1;
                    m_pending <= frame_result(waveform_in, envelope_in, m_gain);
                end
            end else if (m_p == LAST) begin
                m_p    <= 0;
                m_gain <= ramp(m_gain, mute ? '0 : master_gain);
            end else begin
                m_p <= m_p + 1;
                if (m_p + 1 == LAST) m_amp <= m_pending;
            end
            if (sample_valid && m_p != 0) m_ovr <= 1'b1;
            else if (overrun_clr)         m_ovr <= 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("amp_out",      32'(amp_out),      32'(m_amp));
        chk("out_valid",    32'(out_valid),    32'(m_p == LAST));
        chk("busy",         32'(busy),         32'(m_p != 0));
        chk("overrun",      32'(overrun),      32'(m_ovr));
        chk("gain_current", 32'(gain_current), 32'(m_gain));
    end

    // Starts a frame at a negedge; optionally injects a violating strobe inj
    // cycles later. Returns at the negedge after the frame has left DONE.
    task automatic run_frame(input logic [CW-1:0] w, input logic [CW-1:0] e,
                             input int inj, input bit inj_clr);
        int lat;
        waveform_in  = w;
        envelope_in  = e;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        waveform_in  = CW'($urandom);
        envelope_in  = CW'($urandom);
        lat = 0;
        while (!out_valid && lat < 200) begin
            sample_valid = (lat == inj);
            overrun_clr  = (lat == inj) && inj_clr;
            @(negedge clk);
            lat++;
        end
        sample_valid = 1'b0;
        overrun_clr  = 1'b0;
        chk("latency", 32'(lat), 32'(L));
        @(negedge clk);
    endtask

    logic [CW-1:0] d_wave, d_env;
    int prev;

    initial begin
        rst_n = 1'b0; sample_valid = 1'b0; mute = 1'b0; overrun_clr = 1'b0;
        waveform_in = '0; envelope_in = '0; master_gain = '0;
        repeat (3) @(negedge clk);
        chk("reset_amp",  32'(amp_out), 32'h0);
        chk("reset_gain", 32'(gain_current), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Ramp up at unity target; wave 0x80, env 0xFF on both channels.
        master_gain = 8'hFF;
        d_wave = {8'h80, 8'h80};
        d_env  = {8'hFF, 8'hFF};
        for (int k = 1; k <= 17; k++) begin
            run_frame(d_wave, d_env, -1, 1'b0);
            if (k == 1) chk("frame1_amp", 32'(amp_out), 32'h0);
            if (k <= 16) chk("ramp_gain", 32'(gain_current), (k * 16 > 255) ? 32'd255 : 32'(k * 16));
            repeat (6) @(negedge clk);
        end
        chk("unity_amp", 32'(amp_out), 32'h7F7F);

        // Asynchronous reset ten cycles into a frame.
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_amp",   32'(amp_out), 32'h0);
        chk("midrst_busy",  32'(busy), 32'h0);
        chk("midrst_valid", 32'(out_valid), 32'h0);
        chk("midrst_gain",  32'(gain_current), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_frame(d_wave, d_env, -1, 1'b0);
        chk("post_rst_amp", 32'(amp_out), 32'h0);

        // Mid gain 0x80 with independent channels.
        master_gain = 8'h80;
        for (int k = 0; k < 7; k++) run_frame(d_wave, d_env, -1, 1'b0);
        chk("mid_gain", 32'(gain_current), 32'h80);
        run_frame({8'h40, 8'hFF}, {8'h80, 8'hFF}, -1, 1'b0);
        chk("mid_amp", 32'(amp_out), 32'h107F);

        // Overrun: violation 5 cycles in, then clear-with-set, then clear alone.
        run_frame({8'h40, 8'hFF}, {8'h80, 8'hFF}, 4, 1'b0);
        chk("ovr_set", 32'(overrun), 32'h1);
        chk("ovr_amp", 32'(amp_out), 32'h107F);
        run_frame(d_wave, d_env, 2, 1'b1);
        chk("ovr_set_wins", 32'(overrun), 32'h1);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        chk("ovr_cleared", 32'(overrun), 32'h0);

        // Zero envelope and full scale at unity gain.
        master_gain = 8'hFF;
        for (int k = 0; k < 8; k++) run_frame(d_wave, d_env, -1, 1'b0);
        chk("unity_gain", 32'(gain_current), 32'hFF);
        run_frame({8'hFF, 8'hFF}, {8'hFF, 8'h00}, -1, 1'b0);
        chk("zero_full_amp", 32'(amp_out), 32'hFE00);

        // Mute ramps gain down one step per frame; outputs never rise.
        mute = 1'b1;
        prev = 255;
        for (int k = 1; k <= 17; k++) begin
            run_frame(d_wave, d_env, -1, 1'b0);
            if (k <= 16) chk("mute_gain", 32'(gain_current), (255 - 16 * k < 0) ? 32'd0 : 32'(255 - 16 * k));
            chk("mute_no_jump", 32'(int'(amp_out[W-1:0]) <= prev), 32'h1);
            prev = int'(amp_out[W-1:0]);
        end
        chk("mute_amp", 32'(amp_out), 32'h0);
        mute = 1'b0;

        // Randomised frames, gains, mutes, violations and clears.
        for (int k = 0; k < 150; k++) begin
            int inj;
            master_gain = W'($urandom);
            mute        = ($urandom_range(0, 3) == 0);
            inj         = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30)) : -1;
            run_frame(CW'($urandom), CW'($urandom), inj, 1'($urandom));
            if ($urandom_range(0, 4) == 0) overrun_clr = 1'b1;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            overrun_clr = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
